// File: rtl/ctl_seq.sv
// ctl_seq: registered CTL decode for the AR/ARX/MQ strobes and ADX carry-in.
// A LONG microword repeats its double-word AD step N times while holding off CRAM.
module ctl_seq #(
  parameter int WORD  = 36,
  parameter int SC_W  = 6,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CRAM_valid,
  input  logic             CRAM_ADcarry,
  input  logic [SEL_W-1:0] CRAM_ARsel,
  input  logic [SEL_W-1:0] CRAM_ARXsel,
  input  logic [1:0]       CRAM_MQsel,
  input  logic [4:0]       CRAM_SPEC,
  input  logic [SC_W-1:0]  CRAM_steps,
  input  logic [0:WORD-1]  EDP_AR,
  input  logic             PCplus1inh,
  output logic             CTL_busy,
  output logic             CTL_AR00to08load,
  output logic             CTL_AR09to17load,
  output logic             CTL_ARRload,
  output logic             CTL_AR00to11clr,
  output logic             CTL_AR12to17clr,
  output logic             CTL_ARRclr,
  output logic [SEL_W-1:0] CTL_ARL_SEL,
  output logic [SEL_W-1:0] CTL_ARR_SEL,
  output logic [SEL_W-1:0] CTL_ARXL_SEL,
  output logic [SEL_W-1:0] CTL_ARXR_SEL,
  output logic             CTL_ARX_LOAD,
  output logic [1:0]       CTL_MQ_SEL,
  output logic [1:0]       CTL_MQM_SEL,
  output logic             CTL_MQM_EN,
  output logic             ADXcarry36,
  output logic             ADlong,
  output logic             CTL_saveFlags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LONG,
    S_LAST
  } state_e;

  localparam logic [4:0] SP_XCRY = 5'o01;
  localparam logic [4:0] SP_CLRL = 5'o02;
  localparam logic [4:0] SP_CLRR = 5'o03;
  localparam logic [4:0] SP_LONG = 5'o04;
  localparam logic [4:0] SP_MQSH = 5'o05;

  state_e           state_q, state_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ld_q, ld_d;
  logic             clrl_q, clrl_d;
  logic             clrr_q, clrr_d;
  logic [SEL_W-1:0] arsel_q, arsel_d;
  logic [SEL_W-1:0] arxsel_q, arxsel_d;
  logic [1:0]       mqsel_q, mqsel_d;
  logic [1:0]       mqmsel_q, mqmsel_d;
  logic             mqmen_q, mqmen_d;
  logic             carry_q, carry_d;
  logic             adlong_q, adlong_d;
  logic             save_q, save_d;
  logic             x_q, x_d;
  logic             adc_q, adc_d;

  logic             accept;
  logic             x_new;
  logic             save_new;
  logic             unused_ar;

  assign unused_ar = ^EDP_AR[1:WORD-1];
  assign accept    = CRAM_valid && (state_q == S_IDLE);
  assign x_new     = (CRAM_SPEC == SP_XCRY);
  assign save_new  = PCplus1inh & x_new;

  // Next-state decode: accept a microword in IDLE, else replay a LONG step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = 1'b0;
    clrl_d   = 1'b0;
    clrr_d   = 1'b0;
    arsel_d  = arsel_q;
    arxsel_d = arxsel_q;
    mqsel_d  = mqsel_q;
    mqmsel_d = mqmsel_q;
    mqmen_d  = 1'b0;
    carry_d  = 1'b0;
    adlong_d = 1'b0;
    save_d   = save_q;
    x_d      = x_q;
    adc_d    = adc_q;
    if (accept) begin
      x_d      = x_new;
      adc_d    = CRAM_ADcarry;
      ld_d     = 1'b1;
      arsel_d  = CRAM_ARsel;
      arxsel_d = CRAM_ARXsel;
      mqsel_d  = CRAM_MQsel;
      save_d   = save_new;
      carry_d  = ~save_new
               & ((EDP_AR[0] & x_new) ^ CRAM_ADcarry);
      clrl_d   = (CRAM_SPEC == SP_CLRL);
      clrr_d   = (CRAM_SPEC == SP_CLRR);
      if (CRAM_SPEC == SP_MQSH) begin
        mqmen_d  = 1'b1;
        mqmsel_d = CRAM_MQsel;
      end
      if (CRAM_SPEC == SP_LONG) begin
        adlong_d = 1'b1;
        if (CRAM_steps != '0) begin
          cnt_d = CRAM_steps - SC_W'(1);
        end
        if (CRAM_steps == SC_W'(2)) begin
          state_d = S_LAST;
        end else if (CRAM_steps > SC_W'(2)) begin
          state_d = S_LONG;
        end
      end
    end else if (state_q != S_IDLE) begin
      ld_d     = 1'b1;
      adlong_d = 1'b1;
      carry_d  = ~save_q
               & ((EDP_AR[0] & x_q) ^ adc_q);
      cnt_d    = cnt_q - SC_W'(1);
      if (state_q == S_LAST) begin
        state_d = S_IDLE;
      end else if (cnt_q == SC_W'(2)) begin
        state_d = S_LAST;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ld_q     <= 1'b0;
      clrl_q   <= 1'b0;
      clrr_q   <= 1'b0;
      arsel_q  <= '0;
      arxsel_q <= '0;
      mqsel_q  <= '0;
      mqmsel_q <= '0;
      mqmen_q  <= 1'b0;
      carry_q  <= 1'b0;
      adlong_q <= 1'b0;
      save_q   <= 1'b0;
      x_q      <= 1'b0;
      adc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ld_q     <= ld_d;
      clrl_q   <= clrl_d;
      clrr_q   <= clrr_d;
      arsel_q  <= arsel_d;
      arxsel_q <= arxsel_d;
      mqsel_q  <= mqsel_d;
      mqmsel_q <= mqmsel_d;
      mqmen_q  <= mqmen_d;
      carry_q  <= carry_d;
      adlong_q <= adlong_d;
      save_q   <= save_d;
      x_q      <= x_d;
      adc_q    <= adc_d;
    end
  end

  assign CTL_busy         = busy_q;
  assign CTL_AR00to08load = ld_q;
  assign CTL_AR09to17load = ld_q;
  assign CTL_ARRload      = ld_q;
  assign CTL_ARX_LOAD     = ld_q;
  assign CTL_AR00to11clr  = clrl_q;
  assign CTL_AR12to17clr  = clrl_q;
  assign CTL_ARRclr       = clrr_q;
  assign CTL_ARL_SEL      = arsel_q;
  assign CTL_ARR_SEL      = arsel_q;
  assign CTL_ARXL_SEL     = arxsel_q;
  assign CTL_ARXR_SEL     = arxsel_q;
  assign CTL_MQ_SEL       = mqsel_q;
  assign CTL_MQM_SEL      = mqmsel_q;
  assign CTL_MQM_EN       = mqmen_q;
  assign ADXcarry36       = carry_q;
  assign ADlong           = adlong_q;
  assign CTL_saveFlags    = save_q;

endmodule

// File: tb/tb_ctl_seq.sv
// tb_ctl_seq: directed checks of ctl_seq strobes, carry and LONG sequencing.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_ctl_seq;

  localparam int WORD  = 36;
  localparam int SC_W  = 6;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             CRAM_valid;
  logic             CRAM_ADcarry;
  logic [SEL_W-1:0] CRAM_ARsel;
  logic [SEL_W-1:0] CRAM_ARXsel;
  logic [1:0]       CRAM_MQsel;
  logic [4:0]       CRAM_SPEC;
  logic [SC_W-1:0]  CRAM_steps;
  logic [0:WORD-1]  EDP_AR;
  logic             PCplus1inh;
  logic             CTL_busy;
  logic             ld0, ld9, ldr;
  logic             clr0, clr12, clrr;
  logic [SEL_W-1:0] arl, arr, arxl, arxr;
  logic             arx_ld;
  logic [1:0]       mq_sel, mqm_sel;
  logic             mqm_en;
  logic             carry, adlong, save;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ctl_seq #(.WORD(WORD), .SC_W(SC_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset),
    .CRAM_valid(CRAM_valid), .CRAM_ADcarry(CRAM_ADcarry),
    .CRAM_ARsel(CRAM_ARsel), .CRAM_ARXsel(CRAM_ARXsel),
    .CRAM_MQsel(CRAM_MQsel), .CRAM_SPEC(CRAM_SPEC),
    .CRAM_steps(CRAM_steps), .EDP_AR(EDP_AR),
    .PCplus1inh(PCplus1inh), .CTL_busy(CTL_busy),
    .CTL_AR00to08load(ld0), .CTL_AR09to17load(ld9),
    .CTL_ARRload(ldr), .CTL_AR00to11clr(clr0),
    .CTL_AR12to17clr(clr12), .CTL_ARRclr(clrr),
    .CTL_ARL_SEL(arl), .CTL_ARR_SEL(arr),
    .CTL_ARXL_SEL(arxl), .CTL_ARXR_SEL(arxr),
    .CTL_ARX_LOAD(arx_ld), .CTL_MQ_SEL(mq_sel),
    .CTL_MQM_SEL(mqm_sel), .CTL_MQM_EN(mqm_en),
    .ADXcarry36(carry), .ADlong(adlong),
    .CTL_saveFlags(save)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {CTL_busy, ld0, ld9, ldr, clr0, clr12, clrr,
            arl, arr, arxl, arxr, arx_ld, mq_sel, mqm_sel,
            mqm_en, carry, adlong, save};
  endfunction

  task automatic issue(input logic [4:0] spec,
                       input logic [SC_W-1:0] steps);
    CRAM_valid = 1'b1;
    CRAM_SPEC  = spec;
    CRAM_steps = steps;
    tick();
    CRAM_valid = 1'b0;
  endtask

  // Count ADlong / busy cycles after a LONG accept; optional mid pulse.
  task automatic run_long(input bit pulse,
                          input logic [SEL_W-1:0] sel,
                          output int n_ad, output int n_busy,
                          output int n_clr, output int n_bad);
    n_ad = 0; n_busy = 0; n_clr = 0; n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      n_clr += int'(clr0) + int'(clr12) + int'(clrr);
      if (!adlong) break;
      n_ad++;
      n_busy += int'(CTL_busy);
      if (arl != sel || !ld0 || !arx_ld) n_bad++;
      if (pulse && i == 1) begin
        CRAM_valid = 1'b1;
        CRAM_SPEC  = 5'o02;
      end else begin
        CRAM_valid = 1'b0;
      end
      tick();
    end
  endtask

  int a, b, c, d;

  initial begin
    reset = 1'b1;
    CRAM_valid = 0; CRAM_ADcarry = 0;
    CRAM_ARsel = 0; CRAM_ARXsel = 0;
    CRAM_MQsel = 0; CRAM_SPEC = 0;
    CRAM_steps = 0; EDP_AR = '0;
    PCplus1inh = 0;
    tick(); tick();
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;

    // XCRY with PC+1 allowed: carry from AR sign.
    EDP_AR[0] = 1'b1; CRAM_ARsel = 3'd5;
    CRAM_ARXsel = 3'd6; CRAM_MQsel = 2'd1;
    issue(5'o01, 0);
    chk("xcry_carry", carry, 1);
    chk("xcry_save", save, 0);
    chk("xcry_ld", {ld0, ld9, ldr, arx_ld}, 4'hf);
    chk("xcry_sel", {arl, arr, arxl, arxr, mq_sel},
        {3'd5, 3'd5, 3'd6, 3'd6, 2'd1});
    chk("xcry_long", {adlong, CTL_busy}, 0);
    tick();
    chk("idle_strobes", {ld0, ld9, ldr, arx_ld, carry}, 0);
    chk("idle_sel_hold", {arl, arxr, mq_sel},
        {3'd5, 3'd6, 2'd1});

    // XCRY in PI cycle: carry suppressed, flags saved and held.
    PCplus1inh = 1'b1;
    issue(5'o01, 0);
    PCplus1inh = 1'b0;
    chk("pi_carry", carry, 0);
    chk("pi_save", save, 1);
    tick();
    chk("pi_save_hold", save, 1);
    EDP_AR[0] = 1'b0; CRAM_ADcarry = 1'b1;
    issue(5'o00, 0);
    CRAM_ADcarry = 1'b0;
    chk("none_adcarry", carry, 1);
    chk("none_save_clr", save, 0);

    // LONG N=4 with a dropped SPEC=02 pulse mid-sequence.
    CRAM_ARsel = 3'd3;
    issue(5'o04, 6'd4);
    chk("l4_busy_first", CTL_busy, 1);
    run_long(1'b1, 3'd3, a, b, c, d);
    chk("l4_adlong_n", a, 4);
    chk("l4_busy_n", b, 3);
    chk("l4_no_clr", c, 0);
    chk("l4_sel_ld", d, 0);
    tick();
    chk("l4_idle", {adlong, CTL_busy, ld0}, 0);

    // LONG boundaries: N=0, N=1, N=max.
    issue(5'o04, 6'd0);
    run_long(1'b0, 3'd3, a, b, c, d);
    chk("l0_adlong_n", a, 1);
    chk("l0_busy_n", b, 0);
    issue(5'o04, 6'd1);
    run_long(1'b0, 3'd3, a, b, c, d);
    chk("l1_adlong_n", a, 1);
    chk("l1_busy_n", b, 0);
    issue(5'o04, 6'd63);
    run_long(1'b0, 3'd3, a, b, c, d);
    chk("l63_adlong_n", a, 63);
    chk("l63_busy_n", b, 62);
    chk("l63_sel_ld", d, 0);

    // Back-to-back clears are one-shot.
    CRAM_valid = 1'b1; CRAM_SPEC = 5'o02;
    tick();
    CRAM_SPEC = 5'o03;
    chk("clr1", {clr0, clr12, clrr}, 3'b110);
    tick();
    CRAM_valid = 1'b0;
    chk("clr2", {clr0, clr12, clrr}, 3'b001);
    tick();
    chk("clr3", {clr0, clr12, clrr}, 3'b000);

    // MQ shift.
    CRAM_MQsel = 2'd2;
    issue(5'o05, 0);
    chk("mqsh_on", {mqm_en, mqm_sel, mq_sel},
        {1'b1, 2'd2, 2'd2});
    CRAM_MQsel = 2'd0;
    tick();
    chk("mqsh_idle1", {mqm_en, mqm_sel}, {1'b0, 2'd2});
    tick();
    chk("mqsh_idle2", {mqm_en, mqm_sel}, {1'b0, 2'd2});

    // Reset during step 3 of N=5.
    issue(5'o04, 6'd5);
    tick(); tick();
    chk("rst_pre", {adlong, CTL_busy}, 2'b11);
    reset = 1'b1;
    tick();
    chk("rst_mid_long", all_outs(), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_stays_idle", {adlong, CTL_busy, ld0}, 0);
    CRAM_ARsel = 3'd7;
    issue(5'o00, 0);
    chk("rst_accept", {ld0, arl, adlong}, {1'b1, 3'd7, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
